ex_mem_rd_tracker: RTL and testbench

Parametrised destination-register tracker for the RV32I core pipeline, sitting after EX and covering the EX/MEM stage and DEPTH-1 older stages (MEM/WB, etc.). Each cycle it captures the EX instruction's rd, write-enable and load flag into a shift pipeline with stall and flush control. It gives NUM_SRC source-operand ports a forwarding-select (youngest matching stage wins) and a load-use hazard flag. It replaces the single 5-bit ex_mem_rd signal and keeps `ex_mem_rd` as a compatibility output.

---
 rtl/ex_mem_rd_pkg.sv | 21 ++
 rtl/rd_fwd_match.sv | 30 +++
 rtl/ex_mem_rd_tracker.sv | 87 ++++++++
 tb/tb_ex_mem_rd_tracker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_rd_pkg.sv
// Shared types for the EX/MEM destination-register tracker.
// Holds the per-stage entry layout and the cleared-entry constructor.
package ex_mem_rd_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      valid;
    logic                      is_load;
  } rd_entry_t;

  function automatic rd_entry_t rd_entry_bubble();
    rd_entry_t e;
    e.rd      = '0;
    e.valid   = 1'b0;
    e.is_load = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/rd_fwd_match.sv
// Priority matcher for one source operand against all tracked stages.
// Youngest matching stage wins; x0 never matches.
module rd_fwd_match
  import ex_mem_rd_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  rd_entry_t [DEPTH-1:0]  entries,
  input  logic [REG_ADDR_W-1:0]  src,
  output logic [SEL_W-1:0]       sel,
  output logic                   hit0
);

  always_comb begin
    sel  = '0;
    hit0 = 1'b0;
    if (src != '0) begin
      // Scan oldest to youngest so the lowest index overwrites last.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entries[i].valid && (entries[i].rd == src)) begin
          sel = SEL_W'(i + 1);
        end
      end
    end
    hit0 = (sel == SEL_W'(1));
  end

endmodule

// File: rtl/ex_mem_rd_tracker.sv
// Destination-register tracker for EX/MEM and older stages, with
// forwarding selects and load-use hazard detection per source operand.
module ex_mem_rd_tracker
  import ex_mem_rd_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [REG_ADDR_W-1:0]                ex_rd,
  input  logic                                 ex_reg_write,
  input  logic                                 ex_mem_read,
  input  logic                                 stall,
  input  logic                                 flush,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   src_rs,
  output logic [NUM_SRC-1:0][SEL_W-1:0]        fwd_sel,
  output logic                                 load_use_hazard,
  output logic [REG_ADDR_W-1:0]                ex_mem_rd,
  output logic [DEPTH-1:0]                     stage_valid
);

  rd_entry_t [DEPTH-1:0] entries;
  rd_entry_t [DEPTH-1:0] entries_nxt;
  rd_entry_t             ex_entry;

  logic [SEL_W-1:0]      sel_k  [NUM_SRC];
  logic [NUM_SRC-1:0]    hit0_k;

  always_comb begin
    ex_entry.rd      = ex_rd;
    ex_entry.valid   = ex_reg_write && (ex_rd != '0);
    ex_entry.is_load = ex_mem_read && ex_reg_write && (ex_rd != '0);
  end

  // Flush wins over stall: the bubble still advances older stages.
  always_comb begin
    entries_nxt = entries;
    if (flush) begin
      for (int i = 1; i < DEPTH; i++) begin
        entries_nxt[i] = entries[i-1];
      end
      entries_nxt[0] = rd_entry_bubble();
    end else if (!stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        entries_nxt[i] = entries[i-1];
      end
      entries_nxt[0] = ex_entry;
    end
  end

  // Stage register boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entries <= {DEPTH{rd_entry_bubble()}};
    end else begin
      entries <= entries_nxt;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    rd_fwd_match #(
      .DEPTH      (DEPTH),
      .REG_ADDR_W (REG_ADDR_W),
      .SEL_W      (SEL_W)
    ) u_match (
      .entries (entries),
      .src     (src_rs[k]),
      .sel     (sel_k[k]),
      .hit0    (hit0_k[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_sel[k] = sel_k[k];
    end
    load_use_hazard = (|hit0_k) && entries[0].is_load;
    ex_mem_rd       = entries[0].rd;
    for (int i = 0; i < DEPTH; i++) begin
      stage_valid[i] = entries[i].valid;
    end
  end

endmodule

// File: tb/tb_ex_mem_rd_tracker.sv
// Self-checking bench for ex_mem_rd_tracker: directed scenarios plus a
// randomized run against a stage-list reference model.
module tb_ex_mem_rd_tracker;

  localparam int DEPTH      = 2;
  localparam int NUM_SRC    = 2;
  localparam int REG_ADDR_W = 5;
  localparam int SEL_W      = $clog2(DEPTH + 1);

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic [REG_ADDR_W-1:0]              ex_rd;
  logic                               ex_reg_write;
  logic                               ex_mem_read;
  logic                               stall;
  logic                               flush;
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_rs;
  logic [NUM_SRC-1:0][SEL_W-1:0]      fwd_sel;
  logic                               load_use_hazard;
  logic [REG_ADDR_W-1:0]              ex_mem_rd;
  logic [DEPTH-1:0]                   stage_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of in-flight writers, index 0 youngest.
  int m_rd [DEPTH];
  int m_v  [DEPTH];
  int m_ld [DEPTH];

  ex_mem_rd_tracker #(
    .DEPTH      (DEPTH),
    .NUM_SRC    (NUM_SRC),
    .REG_ADDR_W (REG_ADDR_W),
    .SEL_W      (SEL_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .stall           (stall),
    .flush           (flush),
    .src_rs          (src_rs),
    .fwd_sel         (fwd_sel),
    .load_use_hazard (load_use_hazard),
    .ex_mem_rd       (ex_mem_rd),
    .stage_valid     (stage_valid)
  );

  always #5 clk = ~clk;

  function automatic int exp_fwd(input int s);
    if (s == 0) return 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] != 0 && m_rd[i] == s) return i + 1;
    end
    return 0;
  endfunction

  function automatic int exp_haz();
    int h = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (exp_fwd(int'(src_rs[k])) == 1 && m_ld[0] != 0) h = 1;
    end
    return h;
  endfunction

  function automatic int exp_valid_vec();
    int v = 0;
    for (int i = 0; i < DEPTH; i++) if (m_v[i] != 0) v |= (1 << i);
    return v;
  endfunction

  task automatic set_ex(input int rd, input bit we, input bit mr, input bit st, input bit fl);
    ex_rd        = REG_ADDR_W'(rd);
    ex_reg_write = we;
    ex_mem_read  = mr;
    stall        = st;
    flush        = fl;
  endtask

  // Advance one clock edge and move the model the same way the pipeline should.
  task automatic tick();
    int  nv, nl, nrd;
    bit  w;
    w   = ex_reg_write && (ex_rd != 0);
    nrd = int'(ex_rd);
    nv  = w ? 1 : 0;
    nl  = (w && ex_mem_read) ? 1 : 0;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin m_rd[i] = 0; m_v[i] = 0; m_ld[i] = 0; end
    end else if (flush || !stall) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        m_rd[i] = m_rd[i-1]; m_v[i] = m_v[i-1]; m_ld[i] = m_ld[i-1];
      end
      if (flush) begin
        m_rd[0] = 0; m_v[0] = 0; m_ld[0] = 0;
      end else begin
        m_rd[0] = nrd; m_v[0] = nv; m_ld[0] = nl;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_ex(7, 1, 1, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ex(0, 0, 0, 0, 0);
    src_rs[0] = 5'd5; src_rs[1] = 5'd5;
    #1;
    n_checks++;
    if (ex_mem_rd !== 5'd0) begin n_fail++; $display("FAIL reset_ex_mem_rd: got %0d expected 0", ex_mem_rd); end
    n_checks++;
    if (stage_valid !== '0) begin n_fail++; $display("FAIL reset_stage_valid: got %b expected 0", stage_valid); end
    n_checks++;
    if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b expected 0", load_use_hazard); end
    for (int k = 0; k < NUM_SRC; k++) begin
      n_checks++;
      if (fwd_sel[k] !== '0) begin n_fail++; $display("FAIL reset_fwd_sel[%0d]: got %0d expected 0", k, fwd_sel[k]); end
    end
  endtask

  task automatic test_basic_forward();
    set_ex(7, 1, 0, 0, 0);
    tick();
    set_ex(0, 0, 0, 0, 0);
    src_rs[0] = 5'd7; src_rs[1] = 5'd0;
    #1;
    n_checks++;
    if (fwd_sel[0] !== 2'd1) begin n_fail++; $display("FAIL basic_fwd_stage0: got %0d expected 1", fwd_sel[0]); end
    n_checks++;
    if (ex_mem_rd !== 5'd7) begin n_fail++; $display("FAIL basic_ex_mem_rd: got %0d expected 7", ex_mem_rd); end
    tick();
    n_checks++;
    if (fwd_sel[0] !== 2'd2) begin n_fail++; $display("FAIL basic_fwd_stage1: got %0d expected 2", fwd_sel[0]); end
    tick();
    n_checks++;
    if (fwd_sel[0] !== 2'd0) begin n_fail++; $display("FAIL basic_fwd_retired: got %0d expected 0", fwd_sel[0]); end
  endtask

  task automatic test_priority();
    set_ex(3, 1, 0, 0, 0);
    tick();
    tick();
    set_ex(0, 0, 0, 0, 0);
    src_rs[0] = 5'd3;
    #1;
    n_checks++;
    if (fwd_sel[0] !== 2'd1) begin n_fail++; $display("FAIL priority_youngest: got %0d expected 1", fwd_sel[0]); end
    n_checks++;
    if (stage_valid !== 2'b11) begin n_fail++; $display("FAIL priority_valid: got %b expected 11", stage_valid); end
  endtask

  task automatic test_x0_nowrite();
    set_ex(0, 1, 0, 0, 0);
    tick();
    n_checks++;
    if (stage_valid[0] !== 1'b0) begin n_fail++; $display("FAIL x0_valid: got %b expected 0", stage_valid[0]); end
    set_ex(9, 0, 0, 0, 0);
    tick();
    set_ex(0, 0, 0, 0, 0);
    src_rs[0] = 5'd0; src_rs[1] = 5'd9;
    #1;
    n_checks++;
    if (stage_valid[0] !== 1'b0) begin n_fail++; $display("FAIL nowrite_valid: got %b expected 0", stage_valid[0]); end
    n_checks++;
    if (fwd_sel[0] !== 2'd0) begin n_fail++; $display("FAIL x0_fwd: got %0d expected 0", fwd_sel[0]); end
    n_checks++;
    if (fwd_sel[1] !== 2'd0) begin n_fail++; $display("FAIL nowrite_fwd: got %0d expected 0", fwd_sel[1]); end
  endtask

  task automatic test_load_use();
    set_ex(12, 1, 1, 0, 0);
    tick();
    set_ex(0, 0, 0, 0, 0);
    src_rs[0] = 5'd1; src_rs[1] = 5'd12;
    #1;
    n_checks++;
    if (load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL load_use_set: got %b expected 1", load_use_hazard); end
    set_ex(0, 0, 0, 1, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL load_use_stall%0d: got %b expected 1", c, load_use_hazard); end
    end
    set_ex(0, 0, 0, 0, 0);
    tick();
    n_checks++;
    if (fwd_sel[1] !== 2'd2) begin n_fail++; $display("FAIL load_use_release_fwd: got %0d expected 2", fwd_sel[1]); end
    n_checks++;
    if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b expected 0", load_use_hazard); end
  endtask

  task automatic test_flush_over_stall();
    set_ex(4, 1, 0, 0, 0);
    tick();
    set_ex(6, 1, 0, 1, 1);
    tick();
    set_ex(0, 0, 0, 0, 0);
    src_rs[0] = 5'd6; src_rs[1] = 5'd4;
    #1;
    n_checks++;
    if (stage_valid !== 2'b10) begin n_fail++; $display("FAIL flush_valid: got %b expected 10", stage_valid); end
    n_checks++;
    if (ex_mem_rd !== 5'd0) begin n_fail++; $display("FAIL flush_bubble_rd: got %0d expected 0", ex_mem_rd); end
    n_checks++;
    if (fwd_sel[0] !== 2'd0) begin n_fail++; $display("FAIL flush_fwd_flushed: got %0d expected 0", fwd_sel[0]); end
    n_checks++;
    if (fwd_sel[1] !== 2'd2) begin n_fail++; $display("FAIL flush_fwd_shifted: got %0d expected 2", fwd_sel[1]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      set_ex($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < NUM_SRC; k++) src_rs[k] = REG_ADDR_W'($urandom_range(0, 7));
      #1;
      for (int k = 0; k < NUM_SRC; k++) begin
        n_checks++;
        if (int'(fwd_sel[k]) != exp_fwd(int'(src_rs[k])) || $isunknown(fwd_sel[k])) begin
          n_fail++;
          $display("FAIL rand_fwd_sel[%0d] cyc %0d: got %0d expected %0d", k, n, fwd_sel[k], exp_fwd(int'(src_rs[k])));
        end
      end
      n_checks++;
      if (int'(load_use_hazard) != exp_haz() || $isunknown(load_use_hazard)) begin
        n_fail++; $display("FAIL rand_hazard cyc %0d: got %b expected %0d", n, load_use_hazard, exp_haz());
      end
      n_checks++;
      if (int'(ex_mem_rd) != m_rd[0] || $isunknown(ex_mem_rd)) begin
        n_fail++; $display("FAIL rand_ex_mem_rd cyc %0d: got %0d expected %0d", n, ex_mem_rd, m_rd[0]);
      end
      n_checks++;
      if (int'(stage_valid) != exp_valid_vec() || $isunknown(stage_valid)) begin
        n_fail++; $display("FAIL rand_stage_valid cyc %0d: got %b expected %0d", n, stage_valid, exp_valid_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_ex(0, 0, 0, 0, 0);
    src_rs = '0;
    for (int i = 0; i < DEPTH; i++) begin m_rd[i] = 0; m_v[i] = 0; m_ld[i] = 0; end
    #2;
    tick();
    tick();
    test_reset();
    test_basic_forward();
    test_priority();
    test_x0_nowrite();
    test_load_use();
    test_flush_over_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
